// File: rtl/sampler_windowed.sv
// Codec frame sampler: writes one sample per L/R frame into a ring buffer and announces sliding analysis windows.
// Optional SAMPLER_MIX_EN: frame sample is the floor-average of left and right instead of left only.
module sampler_windowed #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned HOP_W     = 10,
    parameter int unsigned SLOT_W    = ADDR_W - HOP_W,
    parameter int unsigned WIN_SLOTS = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic [DATA_W-1:0] left_in_data,
    input  logic              left_in_valid,
    output logic              left_in_ready,
    input  logic [DATA_W-1:0] right_in_data,
    input  logic              right_in_valid,
    output logic              right_in_ready,
    output logic [DATA_W-1:0] ring_buf_data,
    output logic [ADDR_W-1:0] ring_buf_addr,
    output logic              ring_buf_wren,
    output logic [SLOT_W-1:0] window_start,
    output logic              go_out,
    input  logic              busy_in,
    output logic              overrun
);

    localparam logic [SLOT_W-1:0] L_WIN_SLOTS = SLOT_W'(WIN_SLOTS);
    localparam logic [SLOT_W-1:0] L_WS_OFS    = SLOT_W'(WIN_SLOTS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_L,
        S_WAIT_R,
        S_WRITE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_left_ready;
    logic              r_right_ready;
    logic [DATA_W-1:0] r_left;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic              r_wren;
    logic [SLOT_W-1:0] r_slots_filled;
    logic [SLOT_W-1:0] r_window_start;
    logic              r_go;
    logic              r_overrun;

    logic              w_left_beat;
    logic              w_right_beat;
    logic [DATA_W-1:0] w_sample;
    logic              w_slot_done;
    logic [SLOT_W-1:0] w_slot;
    logic [SLOT_W-1:0] w_filled_nxt;

    assign w_left_beat  = left_in_valid && r_left_ready;
    assign w_right_beat = right_in_valid && r_right_ready;

`ifdef SAMPLER_MIX_EN
    // Sum at DATA_W+1 bits so the average never overflows; >>> floors toward -inf.
    logic signed [DATA_W:0] w_sum;
    assign w_sum    = $signed({r_left[DATA_W-1], r_left})
                    + $signed({right_in_data[DATA_W-1], right_in_data});
    assign w_sample = DATA_W'(w_sum >>> 1);
`else
    logic w_unused_right;
    assign w_unused_right = ^right_in_data;
    assign w_sample       = r_left;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // A left beat wins over a run drop so a started frame is always finished.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (run) w_state_nxt = S_WAIT_L;
            S_WAIT_L: begin
                if (w_left_beat) w_state_nxt = S_WAIT_R;
                else if (!run)   w_state_nxt = S_IDLE;
            end
            S_WAIT_R: if (w_right_beat) w_state_nxt = S_WRITE;
            S_WRITE:  w_state_nxt = S_WAIT_L;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Slot bookkeeping runs off the registered write so go_out trails wren by one cycle.
    assign w_slot_done  = r_wren && (&r_addr[HOP_W-1:0]);
    assign w_slot       = r_addr[ADDR_W-1:HOP_W];
    assign w_filled_nxt = (r_slots_filled == L_WIN_SLOTS) ? r_slots_filled
                                                          : r_slots_filled + SLOT_W'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_left_ready   <= 1'b0;
            r_right_ready  <= 1'b0;
            r_left         <= '0;
            r_data         <= '0;
            r_addr         <= '0;
            r_wr_ptr       <= '0;
            r_wren         <= 1'b0;
            r_slots_filled <= '0;
            r_window_start <= '0;
            r_go           <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_left_ready  <= (w_state_nxt == S_WAIT_L);
            r_right_ready <= (w_state_nxt == S_WAIT_R);
            r_wren        <= 1'b0;
            r_go          <= 1'b0;
            if (w_left_beat) r_left <= left_in_data;
            if (w_right_beat) begin
                r_wren   <= 1'b1;
                r_addr   <= r_wr_ptr;
                r_data   <= w_sample;
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_slot_done) begin
                r_slots_filled <= w_filled_nxt;
                if (w_filled_nxt == L_WIN_SLOTS) begin
                    r_go           <= 1'b1;
                    r_window_start <= w_slot - L_WS_OFS;
                end
            end
            if (r_go && busy_in) r_overrun <= 1'b1;
        end
    end

    assign left_in_ready  = r_left_ready;
    assign right_in_ready = r_right_ready;
    assign ring_buf_data  = r_data;
    assign ring_buf_addr  = r_addr;
    assign ring_buf_wren  = r_wren;
    assign window_start   = r_window_start;
    assign go_out         = r_go;
    assign overrun        = r_overrun;

endmodule

// File: tb/tb_sampler_windowed.sv
// Directed bench for sampler_windowed: frames are driven, expected writes/windows queued, then checked on output.
module tb_sampler_windowed;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 13;
    localparam int unsigned SW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          run;
    logic [DW-1:0] left_in_data;
    logic          left_in_valid;
    logic          left_in_ready;
    logic [DW-1:0] right_in_data;
    logic          right_in_valid;
    logic          right_in_ready;
    logic [DW-1:0] ring_buf_data;
    logic [AW-1:0] ring_buf_addr;
    logic          ring_buf_wren;
    logic [SW-1:0] window_start;
    logic          go_out;
    logic          busy_in;
    logic          overrun;

    always #5 clk = ~clk;

    sampler_windowed dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .run            (run),
        .left_in_data   (left_in_data),
        .left_in_valid  (left_in_valid),
        .left_in_ready  (left_in_ready),
        .right_in_data  (right_in_data),
        .right_in_valid (right_in_valid),
        .right_in_ready (right_in_ready),
        .ring_buf_data  (ring_buf_data),
        .ring_buf_addr  (ring_buf_addr),
        .ring_buf_wren  (ring_buf_wren),
        .window_start   (window_start),
        .go_out         (go_out),
        .busy_in        (busy_in),
        .overrun        (overrun)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            due;
        logic [SW-1:0] ws;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            m_ptr = 0;
    int            m_filled = 0;
    logic [SW-1:0] m_ws = '0;
    int            frame_no = 0;
    int            first_go = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_sample(input logic [DW-1:0] l, input logic [DW-1:0] r);
`ifdef SAMPLER_MIX_EN
        int s;
        s = int'($signed(l)) + int'($signed(r));
        return DW'(s >>> 1);
`else
        logic [DW-1:0] unused_r;
        unused_r = r;
        return l | (unused_r & '0);
`endif
    endfunction

    task automatic model_reset();
        m_ptr    = 0;
        m_filled = 0;
        m_ws     = '0;
        sb.delete();
    endtask

    task automatic wait_ready(input bit left, input string tag);
        int n = 0;
        while (((left ? left_in_ready : right_in_ready) !== 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk(tag, 32'(left ? left_in_ready : right_in_ready), 32'd1);
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit drop_run);
        exp_t e;
        e.addr = AW'(m_ptr);
        e.data = model_sample(l, r);
        e.due  = 1'b0;
        if (m_ptr % 1024 == 1023) begin
            if (m_filled < 4) m_filled++;
            if (m_filled == 4) begin
                e.due = 1'b1;
                m_ws  = SW'(m_ptr / 1024 - 3);
            end
        end
        e.ws  = m_ws;
        m_ptr = (m_ptr + 1) % 8192;
        sb.push_back(e);

        left_in_data  = l;
        left_in_valid = 1'b1;
        wait_ready(1'b1, "left_ready_timeout");
        @(negedge clk);
        left_in_valid  = 1'b0;
        right_in_data  = r;
        right_in_valid = 1'b1;
        if (drop_run) run = 1'b0;
        wait_ready(1'b0, "right_ready_timeout");
        @(negedge clk);
        right_in_valid = 1'b0;

        e = sb.pop_front();
        chk("wren", 32'(ring_buf_wren), 32'd1);
        chk("addr", 32'(ring_buf_addr), 32'(e.addr));
        chk("data", 32'(ring_buf_data), 32'(e.data));
        @(negedge clk);
        chk("go_out", 32'(go_out), 32'(e.due));
        chk("window_start", 32'(window_start), 32'(e.ws));
        if (go_out === 1'b1 && first_go < 0) first_go = frame_no;
        frame_no++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_lrdy"}, 32'(left_in_ready), 32'd0);
        chk({tag, "_rrdy"}, 32'(right_in_ready), 32'd0);
        chk({tag, "_wren"}, 32'(ring_buf_wren), 32'd0);
        chk({tag, "_addr"}, 32'(ring_buf_addr), 32'd0);
        chk({tag, "_data"}, 32'(ring_buf_data), 32'd0);
        chk({tag, "_ws"}, 32'(window_start), 32'd0);
        chk({tag, "_go"}, 32'(go_out), 32'd0);
        chk({tag, "_ovr"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        reset_n        = 1'b0;
        run            = 1'b0;
        left_in_data   = '0;
        left_in_valid  = 1'b0;
        right_in_data  = '0;
        right_in_valid = 1'b0;
        busy_in        = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        chk_all_zero("idle");
        run = 1'b1;

        // Priming plus first window: first pulse must follow frame 4095.
        for (int i = 0; i < 4096; i++) send_frame(DW'(i), DW'(-i), 1'b0);
        chk("first_go_frame", 32'(first_go), 32'd4095);
        chk("first_ws", 32'(window_start), 32'd0);
        chk("no_overrun", 32'(overrun), 32'd0);

        // Through the address wrap; frame 9215 completes slot 0 again.
        for (int i = 4096; i < 9215; i++) send_frame(DW'(i), DW'(-i), 1'b0);
        chk("no_overrun_pre", 32'(overrun), 32'd0);
        busy_in = 1'b1;
        send_frame(DW'(9215), DW'(-9215), 1'b0);
        chk("ws_after_wrap", 32'(window_start), 32'd5);
        @(negedge clk);
        busy_in = 1'b0;
        chk("overrun_set", 32'(overrun), 32'd1);
        for (int i = 9216; i < 9220; i++) send_frame(DW'(i), DW'(-i), 1'b0);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // Sample path vectors.
        send_frame(16'h7FFF, 16'h7FFF, 1'b0);
        send_frame(16'hFFFD, 16'h0000, 1'b0);
        send_frame(16'h8000, 16'h8000, 1'b0);

        // Run dropped while waiting for right: frame completes, then idle.
        send_frame(16'h0123, 16'h0456, 1'b1);
        @(negedge clk);
        chk("drop_lrdy", 32'(left_in_ready), 32'd0);
        chk("drop_rrdy", 32'(right_in_ready), 32'd0);
        chk("drop_wren", 32'(ring_buf_wren), 32'd0);
        @(negedge clk);
        chk("drop_lrdy2", 32'(left_in_ready), 32'd0);
        run = 1'b1;
        send_frame(16'h0777, 16'h0888, 1'b0);

        // Reset in the middle of a frame.
        left_in_data  = 16'h5A5A;
        left_in_valid = 1'b1;
        wait_ready(1'b1, "mid_left_timeout");
        @(negedge clk);
        left_in_valid = 1'b0;
        reset_n       = 1'b0;
        @(negedge clk);
        chk_all_zero("midreset");
        reset_n = 1'b1;
        model_reset();
        send_frame(16'h1234, 16'h4321, 1'b0);
        chk("post_reset_ovr", 32'(overrun), 32'd0);
        send_frame(16'h2345, 16'h5432, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
